// File: rtl/vmem_burst_ctrl.sv
// Vector memory burst controller: issues strided read or write bursts to all
// enabled lanes, one beat per cycle (reads) or per source handshake (writes),
// and tracks read-data return through a fixed-latency valid pipeline.
module vmem_burst_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned NUM_ELEM       = 64,
  parameter int unsigned READ_LATENCY_B = 1,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic                           cfg_write,
  input  logic [ADDR_WIDTH-1:0]          cfg_base,
  input  logic [ADDR_WIDTH-1:0]          cfg_stride,
  input  logic [COUNT_WIDTH-1:0]         cfg_count,
  input  logic [NUM_ELEM-1:0]            cfg_mask,
  input  logic                           wr_src_valid,
  output logic                           wr_src_ready,
  output logic [NUM_ELEM-1:0]            mem_read_req,
  output logic [ADDR_WIDTH*NUM_ELEM-1:0] mem_read_addr,
  output logic [NUM_ELEM-1:0]            mem_write_req,
  output logic [ADDR_WIDTH*NUM_ELEM-1:0] mem_write_addr,
  output logic                           rd_data_valid,
  output logic                           rd_last,
  output logic                           busy,
  output logic                           done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]                r_state;
  logic [NUM_ELEM-1:0]       r_mask;
  logic [ADDR_WIDTH-1:0]     r_stride;
  logic [ADDR_WIDTH-1:0]     r_acc;
  logic [COUNT_WIDTH-1:0]    r_remain;
  logic [NUM_ELEM-1:0]       r_rd_req;
  logic [NUM_ELEM-1:0]       r_wr_req;
  logic [ADDR_WIDTH-1:0]     r_rd_addr;
  logic [ADDR_WIDTH-1:0]     r_wr_addr;
  logic                      r_rd_beat;
  logic                      r_rd_fin;
  logic [READ_LATENCY_B-1:0] r_vsh;
  logic [READ_LATENCY_B-1:0] r_lsh;

  assign cfg_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign wr_src_ready   = (r_state == S_WRITE);
  assign mem_read_req   = r_rd_req;
  assign mem_write_req  = r_wr_req;
  assign mem_read_addr  = {NUM_ELEM{r_rd_addr}};
  assign mem_write_addr = {NUM_ELEM{r_wr_addr}};
  assign rd_data_valid  = r_vsh[READ_LATENCY_B-1];
  assign rd_last        = r_lsh[READ_LATENCY_B-1];
  assign done           = ((r_state == S_DRAIN) && rd_last) || (r_state == S_FIN);

  // Burst sequencing: state, address accumulator, beat counter, registered requests.
  // Read beat 0 is issued on the acceptance edge so it is visible the next cycle;
  // r_remain then counts the beats still to issue after the one on the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_stride  <= '0;
      r_acc     <= '0;
      r_remain  <= '0;
      r_rd_req  <= '0;
      r_wr_req  <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_rd_beat <= 1'b0;
      r_rd_fin  <= 1'b0;
    end else begin
      r_rd_req  <= '0;
      r_wr_req  <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_rd_beat <= 1'b0;
      r_rd_fin  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_valid) begin
            r_mask   <= cfg_mask;
            r_stride <= cfg_stride;
            if (cfg_count == '0) begin
              r_state <= S_FIN;
            end else if (!cfg_write) begin
              r_rd_req  <= cfg_mask;
              r_rd_addr <= cfg_base;
              r_rd_beat <= 1'b1;
              r_rd_fin  <= (cfg_count == COUNT_WIDTH'(1));
              r_acc     <= cfg_base + cfg_stride;
              r_remain  <= cfg_count - COUNT_WIDTH'(1);
              r_state   <= S_READ;
            end else begin
              r_acc    <= cfg_base;
              r_remain <= cfg_count;
              r_state  <= S_WRITE;
            end
          end
        end
        S_READ: begin
          if (r_remain != '0) begin
            r_rd_req  <= r_mask;
            r_rd_addr <= r_acc;
            r_rd_beat <= 1'b1;
            r_rd_fin  <= (r_remain == COUNT_WIDTH'(1));
            r_acc     <= r_acc + r_stride;
            r_remain  <= r_remain - COUNT_WIDTH'(1);
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_WRITE: begin
          if (wr_src_valid) begin
            r_wr_req  <= r_mask;
            r_wr_addr <= r_acc;
            r_acc     <= r_acc + r_stride;
            r_remain  <= r_remain - COUNT_WIDTH'(1);
            if (r_remain == COUNT_WIDTH'(1)) begin
              r_state <= S_FIN;
            end
          end
        end
        S_DRAIN: begin
          if (rd_last) begin
            r_state <= S_IDLE;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Read-data return pipeline: delays each issued read beat (and its final flag)
  // by READ_LATENCY_B cycles, independent of the lane mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vsh <= '0;
      r_lsh <= '0;
    end else begin
      r_vsh[0] <= r_rd_beat;
      r_lsh[0] <= r_rd_fin;
      for (int unsigned i = 1; i < READ_LATENCY_B; i++) begin
        r_vsh[i] <= r_vsh[i-1];
        r_lsh[i] <= r_lsh[i-1];
      end
    end
  end

endmodule
